// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit (radix-2 shift-add / restoring divide).
// Latency: 34 cycles start-to-done for normal ops; 1 cycle for divide-by-zero / signed overflow.
// Backpressure: start is ignored while busy; the pipeline stalls on busy. flush aborts any state.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state;
  state_t state_nxt;

  // Latched operation context
  logic [2:0]        op_q;
  logic              neg_q;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   opb;   // multiplicand / divisor magnitude
  logic [2*XLEN-1:0] acc;   // {product high, multiplier/product low}; low half doubles as dividend/quotient
  logic [XLEN:0]     rem;   // partial remainder

  // Accept-time decode of the incoming request
  logic            a_signed;
  logic            b_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            div_ovf;
  logic            special;
  logic            neg_in;
  logic            accept;
  logic [XLEN-1:0] special_res;

  assign a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  assign b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign a_neg    = a_signed & operand_a[XLEN-1];
  assign b_neg    = b_signed & operand_b[XLEN-1];
  assign a_mag    = a_neg ? -operand_a : operand_a;
  assign b_mag    = b_neg ? -operand_b : operand_b;
  assign div_zero = op[2] && (operand_b == '0);
  assign div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
                    (operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (operand_b == '1);
  assign special  = div_zero || div_ovf;
  // Remainder follows the dividend sign; product and quotient negate when signs differ
  assign neg_in   = (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);
  assign accept   = start && !flush && ((state == IDLE) || (state == DONE));

  // Results that bypass the iterative datapath
  always_comb begin
    special_res = '0;
    if (div_zero) special_res = op[1] ? operand_a : '1;
    else          special_res = op[1] ? '0 : operand_a;
  end

  // One radix-2 iteration for multiply and for restoring divide
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] acc_mul;
  logic [XLEN+1:0]   div_trial;
  logic [XLEN:0]     rem_div;
  logic [2*XLEN-1:0] acc_div;

  always_comb begin
    mul_sum   = acc[0] ? ({1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opb}) : {1'b0, acc[2*XLEN-1:XLEN]};
    acc_mul   = {mul_sum, acc[XLEN-1:1]};
    div_trial = {rem, acc[XLEN-1]} - {2'b00, opb};
    if (!div_trial[XLEN+1]) begin
      rem_div = div_trial[XLEN:0];
      acc_div = {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], 1'b1};
    end else begin
      rem_div = {rem[XLEN-1:0], acc[XLEN-1]};
      acc_div = {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], 1'b0};
    end
  end

  // Sign fix-up and result selection in the FIX cycle
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   remv;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    prod = neg_q ? -acc : acc;
    quot = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    remv = neg_q ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    case (op_q)
      OP_MUL:                       fix_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res = quot;
      default:                      fix_res = remv;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) state_nxt = special ? DONE : CALC;
          else       state_nxt = IDLE;
        end
        CALC:    state_nxt = (cnt == CNT_W'(XLEN-1)) ? FIX : CALC;
        FIX:     state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Status outputs decoded from state
  always_comb begin
    busy = (state == CALC) || (state == FIX);
    done = (state == DONE);
  end

  // Datapath: latch at accept, iterate in CALC, register result in FIX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      neg_q  <= 1'b0;
      cnt    <= '0;
      opb    <= '0;
      acc    <= '0;
      rem    <= '0;
      result <= '0;
    end else if (accept) begin
      op_q  <= op;
      neg_q <= neg_in;
      cnt   <= '0;
      opb   <= b_mag;
      acc   <= {{XLEN{1'b0}}, a_mag};
      rem   <= '0;
      if (special) result <= special_res;
    end else if (state == CALC) begin
      cnt <= cnt + 1'b1;
      if (op_q[2]) begin
        acc <= acc_div;
        rem <= rem_div;
      end else begin
        acc <= acc_mul;
      end
    end else if ((state == FIX) && !flush) begin
      result <= fix_res;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with a per-cycle reference model of busy/done/result.
// Latency: model predicts 34-cycle normal and 1-cycle special-case completion.
// Backpressure: model ignores start while an operation is in flight; flush clears it.
module tb_muldiv_unit;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int t0 = 0;
  int done_cnt = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .result(result)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Architectural result of an M-extension op
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, za, zb, p;
    int ai, bi;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    za = {32'h0, a};
    zb = {32'h0, b};
    ai = a;
    bi = b;
    model = '0;
    case (o)
      MUL:    begin p = za * zb; model = p[31:0];  end
      MULH:   begin p = sa * sb; model = p[63:32]; end
      MULHSU: begin p = sa * zb; model = p[63:32]; end
      MULHU:  begin p = za * zb; model = p[63:32]; end
      DIV: begin
        if (b == 0) model = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) model = 32'h80000000;
        else model = ai / bi;
      end
      DIVU:   model = (b == 0) ? 32'hFFFFFFFF : a / b;
      REM: begin
        if (b == 0) model = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) model = 32'h0;
        else model = ai % bi;
      end
      default: model = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    return o[2] && ((b == 0) || (!o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  // Model: cycles of busy remaining, done flag, visible result
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_result = '0;
  logic [31:0] m_pending = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_done = 1'b0; m_result = '0; m_pending = '0;
    end else if (flush) begin
      m_left = 0; m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_result = m_pending;
      end
    end else if (start) begin
      if (is_special(op, operand_a, operand_b)) begin
        m_done = 1'b1;
        m_result = model(op, operand_a, operand_b);
      end else begin
        m_done = 1'b0;
        m_left = 33;
        m_pending = model(op, operand_a, operand_b);
      end
    end else begin
      m_done = 1'b0;
    end
  end

  // Per-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    tests++;
    if (done === 1'b1) done_cnt++;
    if (busy !== (m_left > 0) || done !== m_done || result !== m_result) begin
      fails++;
      if (fails < 30)
        $display("FAIL cycle_check t=%0t busy=%b done=%b result=%h, required busy=%b done=%b result=%h",
                 $time, busy, done, result, (m_left > 0), m_done, m_result);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Present one request; returns just after the accepting edge
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit now);
    if (!now) begin
      @(posedge clk); #2;
    end
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(posedge clk); #2;
    t0 = cyc;
    start = 1'b0;
    operand_a = $urandom;
    operand_b = $urandom;
  endtask

  // Wait (bounded) for done; check latency and result; returns in the DONE cycle
  task automatic wait_done(input string name, input logic [31:0] exp, input int exp_lat);
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (done !== 1'b1 && guard < 200);
    if (done !== 1'b1) begin
      tests++; fails++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end else begin
      check({name, "_lat"}, 32'(cyc - t0 + 1), 32'(exp_lat));
      check({name, "_res"}, result, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    bit          b2b;
    string       name;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, 0, "mul_7_m3"});
    vecs.push_back('{MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34, 0, "mulh_min"});
    vecs.push_back('{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 0, "mulhu_max"});
    vecs.push_back('{MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 0, "mulhsu_m1"});
    vecs.push_back('{DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 0, "div_m7_2"});
    vecs.push_back('{REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 0, "rem_m7_2"});
    vecs.push_back('{DIVU,   32'd100,      32'd7,        32'd14,       34, 1, "divu_b2b"});
    vecs.push_back('{REMU,   32'd100,      32'd7,        32'd2,        34, 1, "remu_b2b"});
    vecs.push_back('{REM,    32'd7,        32'hFFFFFFFE, 32'd1,        34, 0, "rem_7_m2"});
    vecs.push_back('{DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1,  0, "div_by0"});
    vecs.push_back('{REMU,   32'd5,        32'd0,        32'd5,        1,  1, "remu_by0"});
    vecs.push_back('{DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  0, "div_ovf"});
    vecs.push_back('{REM,    32'h80000000, 32'hFFFFFFFF, 32'h0,        1,  0, "rem_ovf"});

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Directed vectors; b2b entries start in the previous DONE cycle
    foreach (vecs[i]) begin
      check({"model_", vecs[i].name}, model(vecs[i].o, vecs[i].a, vecs[i].b), vecs[i].exp);
      issue(vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].b2b);
      wait_done(vecs[i].name, vecs[i].exp, vecs[i].lat);
    end

    // Flush mid-CALC: no done, result keeps the prior value
    issue(DIVU, 32'd100, 32'd7, 0);
    wait_done("divu_pre_flush", 32'd14, 34);
    issue(MUL, 32'h1234, 32'h10, 0);
    repeat (9) @(posedge clk);
    #2 flush = 1'b1;
    @(posedge clk); #2 flush = 1'b0;
    @(negedge clk);
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_result", result, 32'd14);
    done_cnt = 0;
    repeat (40) @(negedge clk);
    check("flush_no_done", 32'(done_cnt), 32'd0);

    // Start while busy is ignored
    issue(MUL, 32'd3, 32'd4, 0);
    repeat (5) @(posedge clk);
    #2 start = 1'b1; op = DIVU; operand_a = 32'd100; operand_b = 32'd7;
    @(posedge clk); #2 start = 1'b0;
    wait_done("mul_3_4", 32'd12, 34);

    // flush and start together: start dropped
    @(posedge clk); #2 start = 1'b1; flush = 1'b1; op = MUL;
    @(posedge clk); #2 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_start_busy", {31'b0, busy}, 32'd0);
    check("flush_start_done", {31'b0, done}, 32'd0);

    // Asynchronous reset mid-CALC
    issue(MULHU, 32'hFFFFFFFF, 32'h2, 0);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    check("arst_result", result, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    issue(REMU, 32'd100, 32'd7, 0);
    wait_done("remu_after_rst", 32'd2, 34);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide execute unit for the M extension. It sits directly downstream of instruction decode and receives the M-extension operations that decode classifies: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- It uses a start/done handshake, so the pipeline stalls on `busy`.
- It is one radix-2 shift-add / restoring-divide datapath shared by all eight ops.

Parameters:
- XLEN, 32, operand and result width.
- CNT_W, $clog2(XLEN)+1, width of the iteration counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request. Sampled only when state is IDLE or DONE.
- flush  input  1  abort the current operation. Has priority over start.
- op  input  3  M-extension funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operand_a  input  XLEN  rs1 value (multiplicand / dividend).
- operand_b  input  XLEN  rs2 value (multiplier / divisor).
- busy  output  1  high while in CALC or FIX.
- done  output  1  one-cycle pulse. High exactly while in DONE.
- result  output  XLEN  registered result. Held until the next accepted start.

Behaviour:

Reset and clocking
- One clock. Reset is asynchronous, active-low, on rst_n.
- On reset: state=IDLE, busy=0, done=0, result=0, all internal registers cleared.
- Reset mid-operation discards the operation; no done is produced.

States
- IDLE, CALC, FIX, DONE.

Accept (edge E0)
- start=1 with state in {IDLE, DONE} and flush=0 latches op, operand_a and operand_b.
- Sign handling at accept:
  - MULH: both operands signed; take absolute values.
  - MULHSU: only operand_a signed.
  - DIV/REM: both signed.
  - Unsigned ops: operands are used raw.
  - The negate-result flag is recorded.
- Counter cleared.
- Next state:
  - CALC in the normal case.
  - Special case: result is loaded directly and next state is DONE (done visible in the cycle after E0, i.e. 1-cycle latency).

Special cases
- Divide by zero (operand_b==0):
  - DIV, DIVU → all ones.
  - REM, REMU → operand_a.
- Signed overflow (DIV/REM with operand_a=0x80000000 and operand_b=0xFFFFFFFF):
  - DIV → 0x80000000.
  - REM → 0.
- MUL ops have no special cases.

CALC
- One iteration per cycle, XLEN cycles (edges E1..EXLEN).
- Multiply: 2*XLEN-bit accumulator, shift-add on each multiplier bit.
- Divide: restoring step, producing one quotient bit per cycle; the partial remainder is XLEN+1 bits.
- When the counter reaches XLEN-1, next state is FIX.

FIX (one cycle)
- Apply two's-complement negation when the flag is set:
  - Product: negated when the operand signs differ.
  - Quotient: negated when the signs differ.
  - Remainder: takes the sign of the dividend.
- Select the result:
  - MUL: low XLEN bits.
  - MULH/MULHSU/MULHU: high XLEN bits.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- Register result. Next state is DONE.

Latency and done
- Normal latency: done is high in the cycle after edge E(XLEN+1). For XLEN=32, done is high 34 cycles after the start cycle; result is valid at the same time.

DONE
- busy=0, done=1.
- If start=1 in this cycle, the new operation is accepted (back-to-back, no bubble).
- Otherwise next state is IDLE.

start while busy
- Ignored; the operation in flight is unaffected.

flush
- Any state → IDLE on the next edge. done is not asserted and result is unchanged.
- flush and start in the same cycle: flush wins and start is dropped.

Operand stability
- Operands may change after E0 without effect.

Test Plan:
- MUL 7 × 0xFFFFFFFD (−3): start pulse → busy for 33 cycles, done pulse on cycle 34, result=0xFFFFFFEB.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD; REM −7 / 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- DIV 5 / 0 → 0xFFFFFFFF and REMU 5 / 0 → 5, with done in the cycle after start and busy never high. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- flush asserted 10 cycles after start → no done, busy low next cycle, result unchanged. A subsequent MUL 3 × 4 → 12 at the normal latency. A start pulsed while busy is ignored.
- Back-to-back: start asserted in the DONE cycle → second operation accepted with no IDLE cycle. rst_n pulled low mid-CALC → done=0, result=0, busy=0 immediately (asynchronous).
